// File: rtl/spi_slave_rx_frame.sv
// spi_slave_rx_frame: SPI mode-0 slave that receives a fixed-length frame MSB first and replies on miso
//   clk, reset : system clock, synchronous active-high reset
//   sclk, mosi, ss : raw asynchronous SPI inputs (ss active-low)
//   miso       : reply bit, MSB of tx_data first
//   tx_data    : reply word, sampled at frame start
//   rx_data    : last complete received frame
//   rx_valid   : one-cycle strobe after rx_data updates
//   frame_err  : one-cycle strobe when a frame ends abnormally
module spi_slave_rx_frame #(
    parameter int DATA_BYTES  = 2,
    parameter int SYNC_STAGES = 2,
    localparam int FW = 8 * DATA_BYTES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sclk,
    input  logic          mosi,
    input  logic          ss,
    output logic          miso,
    input  logic [FW-1:0] tx_data,
    output logic [FW-1:0] rx_data,
    output logic          rx_valid,
    output logic          frame_err
);
    localparam int CW = $clog2(FW + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sclk_q, mosi_q, ss_q, fill;
    logic sclk_d, ss_d, armed, valid_pend, extra;
    logic sclk_s, mosi_s, ss_s, s_rise, s_fall, ss_rise, ss_fall;
    logic [CW-1:0] cnt;
    logic [FW-1:0] rx_sr, tx_sr, rx_next;
    assign sclk_s  = sclk_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_q[SYNC_STAGES-1];
    assign ss_s    = ss_q[SYNC_STAGES-1];
    assign s_rise  = sclk_s & ~sclk_d;
    assign s_fall  = ~sclk_s & sclk_d;
    assign ss_rise = ss_s & ~ss_d;
    assign ss_fall = ~ss_s & ss_d;
    assign rx_next = {rx_sr[FW-2:0], mosi_s};
    assign miso    = (state != IDLE) & ~ss_s & tx_sr[FW-1];
    // fill marks when the synchronizers hold real post-reset samples; armed then
    // requires ss seen high, so a frame already in progress at reset release is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q     <= '0;
            mosi_q     <= '0;
            ss_q       <= '1;
            fill       <= '0;
            sclk_d     <= 1'b0;
            ss_d       <= 1'b1;
            armed      <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            extra      <= 1'b0;
            valid_pend <= 1'b0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sclk_q     <= {sclk_q[SYNC_STAGES-2:0], sclk};
            mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi};
            ss_q       <= {ss_q[SYNC_STAGES-2:0], ss};
            fill       <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_d     <= sclk_s;
            ss_d       <= ss_s;
            armed      <= armed | (fill[SYNC_STAGES-1] & ss_s);
            rx_valid   <= valid_pend;
            valid_pend <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: if (ss_fall && armed) begin
                    tx_sr <= tx_data;
                    cnt   <= '0;
                    extra <= 1'b0;
                    state <= SHIFT;
                end
                SHIFT: if (ss_rise) begin
                    frame_err <= cnt != '0;
                    state     <= IDLE;
                end else begin
                    if (s_rise) begin
                        rx_sr <= rx_next;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(FW - 1)) begin
                            rx_data    <= rx_next;
                            valid_pend <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                    if (s_fall) tx_sr <= {tx_sr[FW-2:0], 1'b0};
                end
                HOLD: if (ss_rise) begin
                    frame_err <= extra;
                    state     <= IDLE;
                end else if (s_rise) begin
                    extra <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_rx_frame.sv
// tb_spi_slave_rx_frame: randomized scoreboard bench for spi_slave_rx_frame
module tb_spi_slave_rx_frame;
    localparam int FW = 16;
    typedef struct {bit err; logic [FW-1:0] data;} ev_t;
    logic clk = 0, reset = 1, sclk = 0, mosi = 0, ss = 1;
    logic miso, rx_valid, frame_err;
    logic [FW-1:0] tx_data = '0, rx_data, last_good = '0;
    ev_t q[$];
    ev_t mon_e;
    int total = 0, bad = 0;

    spi_slave_rx_frame #(.DATA_BYTES(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
        .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (!reset) begin
        if (rx_valid) begin
            if (q.size() == 0) chk("unexpected_rx_valid", 1, 0);
            else begin
                mon_e = q.pop_front();
                chk("event_is_valid", {31'd0, mon_e.err}, 0);
                chk("rx_data", {16'd0, rx_data}, {16'd0, mon_e.data});
            end
        end
        if (frame_err) begin
            if (q.size() == 0) chk("unexpected_frame_err", 1, 0);
            else begin
                mon_e = q.pop_front();
                chk("event_is_err", {31'd0, mon_e.err}, 1);
            end
        end
    end

    // master side of mode 0: mosi changes while sclk low, miso read just before each rise
    task automatic shift_bits(input logic [31:0] bits, input int n, output logic [FW-1:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            mosi = bits[n-1-i];
            repeat (6) @(negedge clk);
            if (i < FW) got[FW-1-i] = miso;
            sclk = 1;
            repeat (6) @(negedge clk);
            sclk = 0;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic xfer(input logic [31:0] bits, input int n, input logic [FW-1:0] tx, input int gap);
        logic [FW-1:0] got, exp;
        exp = '0;
        for (int i = 0; i < n && i < FW; i++) exp[FW-1-i] = tx[FW-1-i];
        if (n >= FW) begin
            last_good = FW'(bits >> (n - FW));
            q.push_back('{1'b0, last_good});
        end
        if (n > 0 && n != FW) q.push_back('{1'b1, '0});
        tx_data = tx;
        @(negedge clk);
        ss = 0;
        repeat (8) @(negedge clk);
        shift_bits(bits, n, got);
        ss = 1;
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        chk("events_drained", q.size(), 0);
        if (n > 0) chk("miso_word", {16'd0, got}, {16'd0, exp});
        chk("rx_data_held", {16'd0, rx_data}, {16'd0, last_good});
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        logic [FW-1:0] g;
        int n;
        repeat (4) @(negedge clk);
        chk("reset_rx_data", {16'd0, rx_data}, 0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 0);
        chk("reset_frame_err", {31'd0, frame_err}, 0);
        chk("reset_miso", {31'd0, miso}, 0);
        reset = 0;
        repeat (6) @(negedge clk);
        xfer(32'h1234, 16, 16'hA55A, 4);
        xfer(32'h15, 5, 16'h0F0F, 6);
        xfer({15'd0, 16'hBEEF, 1'b1}, 17, 16'hC3C3, 6);
        xfer(32'h00FF, 16, 16'h1234, 4);
        xfer(32'hFF00, 16, 16'h4321, 4);
        chk("b2b_final", {16'd0, rx_data}, 32'hFF00);
        tx_data = 16'h1111;
        ss = 0;
        repeat (8) @(negedge clk);
        shift_bits(32'h5678 >> 7, 9, g);
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        last_good = '0;
        chk("reset_mid_rx_data", {16'd0, rx_data}, 0);
        shift_bits(32'h7, 3, g);
        chk("miso_ignored_frame", {16'd0, g}, 0);
        ss = 1;
        repeat (10) @(negedge clk);
        chk("no_strobe_after_abort", q.size(), 0);
        xfer(32'h9ABC, 16, 16'h5AA5, 6);
        chk("after_reset_frame", {16'd0, rx_data}, 32'h9ABC);
        xfer(32'h0, 0, 16'hFFFF, 6);
        chk("idle_miso", {31'd0, miso}, 0);
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(0, FW + 2);
            xfer($urandom, n, FW'($urandom), $urandom_range(4, 10));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_rx_frame.md
Name: spi_slave_rx_frame

Overview:
- SPI mode-0 slave front end.
- Oversamples external sclk/mosi/ss in the system clock domain and deserializes a fixed-length frame, MSB first.
- Presents the frame as a parallel word with a one-cycle valid strobe to the downstream FND/display logic.
- Shifts a parallel reply word out on miso during the same frame.

Parameters:
- DATA_BYTES, 2, bytes per frame; frame length FW = 8*DATA_BYTES bits.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (>=2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  raw SPI clock from master, asynchronous to clk.
- mosi  input  1  raw SPI data in, asynchronous.
- ss  input  1  raw slave select, active-low, asynchronous.
- miso  output  1  SPI data out.
- tx_data  input  FW  reply word; sampled at frame start.
- rx_data  output  FW  last complete received frame.
- rx_valid  output  1  one-cycle strobe: rx_data just updated.
- frame_err  output  1  one-cycle strobe: frame ended abnormally.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state changes on rising clk.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, miso=0.
  - State IDLE, bit counter 0, extra-edge flag 0.
  - Synchronizer flops: sclk=0, mosi=0, ss=1.
- Input synchronization:
  - sclk, mosi and ss each pass through SYNC_STAGES flops; all three share the same depth so they stay aligned.
  - Edge detect uses one extra register per signal: s_rise, s_fall, ss_fall, ss_rise, each a single-cycle pulse.
- Timing requirement on the master: sclk high and low phases each >=4 clk cycles; ss setup/hold to first/last sclk edge >=4 clk cycles. Behaviour outside this range is undefined.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE: on ss_fall, load tx shift register <= tx_data, clear bit counter and extra-edge flag, go to SHIFT.
  - SHIFT:
    - On s_rise: rx shift register <= {rx_sr[FW-2:0], mosi_sync}; counter +1.
    - When counter reaches FW on that s_rise: rx_data <= assembled word, and rx_valid=1 on the following cycle only; go to HOLD.
    - On s_fall: tx shift register shifts left, filling with 0.
    - On ss_rise with counter in 1..FW-1: frame_err=1 for one cycle, rx_data unchanged, go to IDLE.
    - On ss_rise with counter 0 (ss pulse with no clocks): go to IDLE, no strobe.
  - HOLD:
    - Any s_rise sets the extra-edge flag; no data is captured.
    - On ss_rise: if the flag is set, pulse frame_err one cycle; go to IDLE.
- Simultaneous events: ss_rise has priority over s_rise/s_fall in the same cycle; that edge is discarded.
- miso:
  - Equals tx_sr[FW-1] while synchronized ss=0 and state is SHIFT or HOLD; otherwise 0.
  - The first bit is valid from the cycle after ss_fall detection.
  - Bit k is valid after the (k)th s_fall.
- Latency: rx_valid rises 2 clk cycles after the s_rise pulse of the final bit (1 cycle to update rx_data, 1 registered strobe). Worst case is SYNC_STAGES+3 cycles from the raw sclk edge.
- rx_data holds its value until the next good frame; it is never cleared except by reset.
- A reset asserted mid-frame aborts immediately with no strobes. After release the block waits in IDLE for a fresh ss_fall; a frame already in progress with ss low is ignored until ss goes high and then low again.
- Back-to-back frames: ss high for >=4 clk cycles between frames must be accepted.

Test Plan:
- Send frame 0x12,0x34 with tx_data=0xA55A → rx_data=0x1234, rx_valid high exactly 1 cycle, frame_err stays 0. Bits captured on master miso = 0xA55A.
- Abort after 5 sclk rising edges (ss raised) → frame_err one cycle, rx_data keeps previous value 0x1234, no rx_valid.
- 17 sclk rising edges in one ss window with data 0xBEEF plus 1 extra bit → rx_valid once after bit 16 with rx_data=0xBEEF; frame_err one cycle at ss rise.
- Two back-to-back frames 0x00FF then 0xFF00, ss high 4 clk cycles between → two rx_valid pulses, rx_data ends at 0xFF00.
- Assert reset after 9 bits of frame 0x5678, then run full frame 0x9ABC with fresh ss → no strobe for the aborted frame; rx_data=0x9ABC with one rx_valid.
- ss low then high with no sclk edges → no rx_valid, no frame_err, miso returns to 0.
